instr_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the single-cycle MIPS datapath fetches from. It accepts a byte stream over a valid/ready handshake: a 16-bit word count, the payload words, then a checksum byte. It assembles the bytes into 32-bit big-endian words and writes each one to instruction memory. While loading, it holds the CPU frozen with `cpu_hold`. It releases the CPU only after a successful checksum.

---
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: byte stream (count, big-endian payload words,
// checksum) in, one-cycle imem writes out; holds the CPU frozen until a good checksum.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_ARM,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] hdr_count;
    logic [7:0]  csum_nx;
    logic        last_word;
    logic        word_full;
    logic        in_final;

    // Status outputs decode the state register directly, so they carry no extra latency.
    assign rx_ready  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign cpu_hold  = (state != S_DONE);
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);

    assign accept    = rx_valid && rx_ready;
    assign hdr_count = {count[15:8], rx_data};
    assign csum_nx   = csum + rx_data;
    assign last_word = (16'(word_idx + 16'd1) == count);
    assign word_full = (byte_cnt == 2'd3);
    assign in_final  = (state == S_DONE) || (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ARM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ARM: begin
                state_nx = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (accept) begin
                    state_nx = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    if (32'(hdr_count) > MAX_WORDS) begin
                        state_nx = S_ERR;
                    end else if (hdr_count == 16'd0) begin
                        state_nx = S_CSUM;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && word_full && last_word) begin
                    state_nx = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_nx = (csum_nx == 8'd0) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_nx = S_HDR_HI;
                end
            end
            default: begin
                state_nx = S_ARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            shift_q    <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (in_final && restart) begin
                count    <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end
            if (accept) begin
                csum <= csum_nx;
                case (state)
                    S_HDR_HI: count[15:8] <= rx_data;
                    S_HDR_LO: count[7:0]  <= rx_data;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {shift_q[15:0], rx_data};
                        // Only three bytes are buffered; the fourth goes straight into the write.
                        if (word_full) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {shift_q, rx_data};
                            imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx   <= word_idx + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected imem writes are queued as streams are
// built and compared by a monitor whenever the loader pulses imem_we.
module tb_instr_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [7:0]  tx_q[$];
    logic [31:0] words[$];
    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          watch_hold = 0;
    bit          hold_lost  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                check_val("unexp_we", {31'd0, imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", imem_addr, e.a);
                check_val("wr_data", imem_wdata, e.d);
            end
        end
        if (watch_hold && !cpu_hold) hold_lost = 1;
    end

    // csum_ovr < 0 appends the correct checksum; otherwise its low byte is sent as-is.
    task automatic build_load(input int csum_ovr);
        logic [15:0] n;
        logic [7:0]  s;
        logic [7:0]  b;
        tx_q.delete();
        n = 16'(words.size());
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        s = n[15:8] + n[7:0];
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][31 - 8*k -: 8];
                tx_q.push_back(b);
                s = s + b;
            end
            exp_q.push_back('{BASE + 32'(i) * 32'd4, words[i]});
        end
        if (csum_ovr < 0) tx_q.push_back(8'(8'h00 - s));
        else              tx_q.push_back(8'(csum_ovr));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'(($urandom & 32'hff));
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check_val("rdy_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_all(input int maxgap);
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'd0, rx_ready}, 32'd1);
        check_val("rst_done", {31'd0, load_done}, 32'd0);
        check_val("rst_err", {31'd0, load_err}, 32'd0);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        check_val({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
        check_val({tag, "_err"}, {31'd0, load_err}, {31'd0, err});
        check_val({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !done});
        check_val({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        check_val({tag, "_pend"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; restart = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_ready", {31'd0, rx_ready}, 32'd0);
        check_val("reset_we", {31'd0, imem_we}, 32'd0);
        check_val("reset_addr", imem_addr, BASE);
        check_val("reset_wdata", imem_wdata, 32'd0);
        check_val("reset_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("reset_status", {30'd0, load_done, load_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arm_ready", {31'd0, rx_ready}, 32'd1);

        // Two-word load from the test plan
        words = '{32'h2008_0005, 32'h0800_0000};
        build_load(-1);
        send_all(0);
        check_status("two_word", 1'b1, 1'b0);
        do_restart();

        // Same words, bad checksum
        build_load(0);
        send_all(0);
        check_status("bad_csum", 1'b0, 1'b1);
        do_restart();

        // Oversized header: error right after the second byte, no writes
        tx_q = '{8'h01, 8'h01};
        send_all(0);
        check_status("too_big", 1'b0, 1'b1);
        do_restart();

        // Zero-count load
        words.delete();
        build_load(-1);
        send_all(0);
        check_status("zero_cnt", 1'b1, 1'b0);
        do_restart();

        // Two-word load with random valid gaps
        words = '{32'h2008_0005, 32'h0800_0000};
        build_load(-1);
        send_all(5);
        check_status("gaps", 1'b1, 1'b0);
        do_restart();

        // Exactly MAX_WORDS words is accepted
        words.delete();
        for (int i = 0; i < int'(MAXW); i++) words.push_back($urandom);
        build_load(-1);
        send_all(1);
        check_status("max_words", 1'b1, 1'b0);
        do_restart();

        // Reset after 6 bytes, then a fresh load
        watch_hold = 1;
        words = '{32'h2008_0005, 32'h0800_0000};
        build_load(-1);
        for (int i = 0; i < 6; i++) send_byte(tx_q.pop_front(), 0);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_ready", {31'd0, rx_ready}, 32'd0);
        check_val("midrst_we", {31'd0, imem_we}, 32'd0);
        rst_n = 1'b1;
        words = '{32'h1122_3344, 32'h5566_7788};
        build_load(-1);
        while (tx_q.size() > 1) send_byte(tx_q.pop_front(), 0);
        watch_hold = 0;
        send_byte(tx_q.pop_front(), 0);
        check_val("midrst_hold_kept", {31'd0, hold_lost}, 32'd0);
        check_status("midrst", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
